seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display.
//  Replaces the divided-clock approach with an in-block prescaler used as a clock enable.
//  Sequences digit slots, inserts anti-ghosting blanking and decodes hex nibbles.
//  Accepts new display values from the CPU-side debug/IO logic through a valid/ready handshake.
//  Swaps new values in atomically at frame boundaries.
// PARAMETERS
//  SLOT_CYCLES   200000  clk cycles per digit slot (2 ms @100 MHz; 8 slots = 62.5 Hz frame)
//  BLANK_CYCLES  2000    cycles at start of each slot with all anodes off; must be < SLOT_CYCLES
//  NUM_DIGITS    8       digits scanned; index width = clog2(NUM_DIGITS)
//  LZ_SUPPRESS   1       1 = blank leading-zero digits (digit 0 always shown)
// PORTS
//  clk_100M    in   1             system clock, 100 MHz
//  rst         in   1             asynchronous, active-high reset
//  disp_data   in   4*NUM_DIGITS  hex value; nibble i -> digit i (digit 0 = rightmost)
//  disp_dp     in   NUM_DIGITS    decimal-point enables, bit i -> digit i (1 = lit)
//  disp_valid  in   1             producer offers disp_data/disp_dp
//  disp_ready  out  1             pending buffer empty; transfer when valid&ready
//  an          out  NUM_DIGITS    anode enables, active low
//  seg         out  7             segments {g,f,e,d,c,b,a}, active low
//  dp          out  1             decimal point, active low
//  frame_done  out  1             1-cycle pulse at each frame boundary
// BEHAVIOUR
//  Reset (async, immediate):
//   - cnt=0, idx=0, state=BLANK, shadow=0, pending empty.
//   - an=all 1, seg=7'h7F, dp=1, frame_done=0; disp_ready=1 (combinational ~pend_full).
//  Prescaler:
//   - cnt counts 0..SLOT_CYCLES-1, then wraps to 0.
//   - On wrap, idx increments; NUM_DIGITS-1 wraps to 0.
//  FSM (2 states, per slot):
//   - BLANK: cnt < BLANK_CYCLES.
//   - SHOW: remainder of slot.
//   - BLANK->SHOW at cnt==BLANK_CYCLES-1.
//   - SHOW->BLANK at cnt==SLOT_CYCLES-1.
//  Outputs are registered: reflect state/idx with 1-cycle latency.
//   - BLANK: an=all 1, seg=7'h7F, dp=1.
//   - SHOW: an[idx]=0, others 1; seg=decode(shadow nibble idx); dp=~shadow_dp[idx].
//  Leading-zero suppression (LZ_SUPPRESS=1):
//   - Digit i>0 is suppressed when nibbles i..NUM_DIGITS-1 are all zero.
//   - Suppressed digit: anode still driven, seg=7'h7F; dp still honoured.
//  Decode (active low):
//   - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
//   - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
//  Handshake (1-deep pending register):
//   - valid&ready captures data+dp into pending; pend_full=1.
//   - Producer holds data while valid&&!ready.
//  Frame boundary = cnt==SLOT_CYCLES-1 && idx==NUM_DIGITS-1:
//   - frame_done=1 on the next cycle.
//   - If pend_full: shadow<=pending, pend_full<=0; ready rises the following cycle.
//  Simultaneous valid&ready with boundary (pending was empty):
//   - Data is captured into pending only; shown after the next boundary.
//  Rules:
//   - shadow never changes mid-frame.
//   - Reset mid-frame discards pending and shadow; scan restarts at idx 0, BLANK.
// STRUCTURE
//  Package seg7_pkg:
//   - SEG_BLANK=7'h7F constant.
//   - 16-entry hex->segment function/table.
//   - State encoding constants (ST_BLANK, ST_SHOW).
//  Sub-module seg7_hex_decode: combinational 4-bit -> 7-bit, instanced once on the selected nibble.
//  Remainder is flat: prescaler, FSM, pending/shadow registers, output registers.
// TESTING (bench params: SLOT_CYCLES=10, BLANK_CYCLES=2, NUM_DIGITS=8; frame = 80 cycles)
//  1. Hold rst -> an=8'hFF, seg=7'h7F, dp=1, disp_ready=1, frame_done=0.
//     Release -> first SHOW of digit 0 after 2 blank cycles (+1 latency).
//  2. Write 32'h12345678, dp=8'h01 -> disp_ready=0.
//     After next frame_done, slot 0 shows an=8'hFE, seg=7'b0000000, dp=0 for 8 cycles.
//     Slot 7 shows an=8'h7F, seg=7'b1111001.
//  3. LZ_SUPPRESS=1, write 32'h00000A05:
//     - digits 0,1,2 show 5,0,A;
//     - digits 3..7 show an active, seg=7'h7F.
//     LZ_SUPPRESS=0 -> digits 3..7 show 1000000.
//  4. Back-to-back writes: second write sees disp_ready=0 and holds.
//     It is accepted 1 cycle after the boundary; frame_done pulses exactly every 80 cycles.
//  5. valid asserted on the boundary cycle with pending empty -> accepted.
//     Display unchanged this frame; new value appears only after the following frame_done.
//  6. Assert rst asynchronously mid-SHOW at idx=5 with pending full:
//     - an=8'hFF without a clock edge;
//     - after release, idx restarts at 0, shadow=0, disp_ready=1.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, FSM state encoding and the hex-to-segment table
// for the 7-segment scan controller.
//   SEG_BLANK  all segments off (active low)
//   state_t    scan FSM state: ST_BLANK (anti-ghosting gap) / ST_SHOW
//   hex2seg()  4-bit nibble -> {g,f,e,d,c,b,a}, active low
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low segment pattern.
//   i_nib  in   4  hex digit
//   o_seg  out  7  segments {g,f,e,d,c,b,a}, active low
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = hex2seg(i_nib);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display. A prescaler (used as a slot enable, not a
// divided clock) steps through digit slots; each slot starts with a blanking
// gap to avoid ghosting. New values arrive via valid/ready into a 1-deep
// pending register and are swapped into the displayed shadow only at frame
// boundaries so a frame never shows a mix of old and new digits.
//   clk_100M    in   1             system clock
//   rst         in   1             asynchronous active-high reset
//   disp_data   in   4*NUM_DIGITS  nibble i -> digit i (digit 0 rightmost)
//   disp_dp     in   NUM_DIGITS    decimal-point enables (1 = lit)
//   disp_valid  in   1             producer offers data
//   disp_ready  out  1             pending buffer empty
//   an          out  NUM_DIGITS    anode enables, active low
//   seg         out  7             segments {g,f,e,d,c,b,a}, active low
//   dp          out  1             decimal point, active low
//   frame_done  out  1             1-cycle pulse after each frame boundary
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SLOT_CYCLES  = 200000,
  parameter int BLANK_CYCLES = 2000,
  parameter int NUM_DIGITS   = 8,
  parameter int LZ_SUPPRESS  = 1
)(
  input  logic                    clk_100M,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] disp_data,
  input  logic [NUM_DIGITS-1:0]   disp_dp,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]                r_cnt;
  logic [IDX_W-1:0]                r_idx;
  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [NUM_DIGITS-1:0][3:0]      r_shadow;
  logic [NUM_DIGITS-1:0]           r_shadow_dp;
  logic [NUM_DIGITS-1:0][3:0]      r_pend;
  logic [NUM_DIGITS-1:0]           r_pend_dp;
  logic                            r_pend_full;
  logic                            w_slot_end;
  logic                            w_frame_end;
  logic                            w_accept;
  logic [NUM_DIGITS-1:0]           w_lz;
  logic                            w_any_nz;
  logic [3:0]                      w_nib;
  logic [6:0]                      w_dec_seg;
  logic [NUM_DIGITS-1:0]           w_an_nxt;
  logic [6:0]                      w_seg_nxt;
  logic                            w_dp_nxt;
  logic [NUM_DIGITS-1:0]           r_an;
  logic [6:0]                      r_seg;
  logic                            r_dp;
  logic                            r_frame_done;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  assign disp_ready  = ~r_pend_full;
  assign w_accept    = disp_valid && ~r_pend_full;

  // Prescaler: slot counter plus digit index
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) r_state <= ST_BLANK;
    else     r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BLANK: if (r_cnt == CNT_BLANK_LAST) w_state_nxt = ST_SHOW;
      ST_SHOW:  if (w_slot_end)              w_state_nxt = ST_BLANK;
    endcase
  end

  // Pending/shadow: accept only when empty, so capture and swap never coincide.
  // A capture on the boundary cycle lands in pending and waits a full frame.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      r_pend      <= '0;
      r_pend_dp   <= '0;
      r_pend_full <= 1'b0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
    end else if (w_accept) begin
      r_pend      <= disp_data;
      r_pend_dp   <= disp_dp;
      r_pend_full <= 1'b1;
    end else if (w_frame_end && r_pend_full) begin
      r_shadow    <= r_pend;
      r_shadow_dp <= r_pend_dp;
      r_pend_full <= 1'b0;
    end
  end

  // Leading-zero mask: digit i>0 blanked when it and every digit above it are 0
  always_comb begin
    w_lz     = '0;
    w_any_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_any_nz = w_any_nz | (|r_shadow[i]);
      w_lz[i]  = (LZ_SUPPRESS != 0) && !w_any_nz;
    end
  end

  assign w_nib = r_shadow[r_idx];

  seg7_hex_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec_seg)
  );

  // FSM: outputs (registered below)
  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = SEG_BLANK;
    w_dp_nxt  = 1'b1;
    if (r_state == ST_SHOW) begin
      w_an_nxt[r_idx] = 1'b0;
      w_seg_nxt       = w_lz[r_idx] ? SEG_BLANK : w_dec_seg;
      w_dp_nxt        = ~r_shadow_dp[r_idx];
    end
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      r_an         <= '1;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with SLOT_CYCLES=10, BLANK_CYCLES=2, 8 digits.
// Two instances share stimulus: one with leading-zero suppression, one without.
// Positions (pos) count negedges after the negedge where frame_done is seen;
// digit k is visible at pos 10k+3 .. 10k+10, blank at 10k+1, 10k+2.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] disp_data = '0;
  logic [7:0]  disp_dp = '0;
  logic        disp_valid = 1'b0;
  logic        disp_ready, dp, frame_done;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        ready_nz, dp_nz, fd_nz;
  logic [7:0]  an_nz;
  logic [6:0]  seg_nz;

  seg7_scan_ctrl #(.SLOT_CYCLES(10), .BLANK_CYCLES(2), .NUM_DIGITS(8), .LZ_SUPPRESS(1)) dut (
    .clk_100M(clk), .rst(rst), .disp_data(disp_data), .disp_dp(disp_dp),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .an(an), .seg(seg),
    .dp(dp), .frame_done(frame_done));

  seg7_scan_ctrl #(.SLOT_CYCLES(10), .BLANK_CYCLES(2), .NUM_DIGITS(8), .LZ_SUPPRESS(0)) dut_nz (
    .clk_100M(clk), .rst(rst), .disp_data(disp_data), .disp_dp(disp_dp),
    .disp_valid(disp_valid), .disp_ready(ready_nz), .an(an_nz), .seg(seg_nz),
    .dp(dp_nz), .frame_done(fd_nz));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;
  int pos  = 0;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dpv;
    int          slot;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dpo;
    logic [6:0]  seg_nz;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    pos++;
  endtask

  task automatic goto_pos(input int p);
    while (pos < p) tick();
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    tick();
    while (!frame_done && n < 200) begin
      tick();
      n++;
    end
    chk("frame_done_seen", frame_done, 1);
    pos = 0;
  endtask

  task automatic write(input logic [31:0] d, input logic [7:0] p);
    int n;
    n = 0;
    disp_data  = d;
    disp_dp    = p;
    disp_valid = 1'b1;
    while (!disp_ready && n < 200) begin
      tick();
      n++;
    end
    chk("write_ready", disp_ready, 1);
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic chk_blank(input string nm);
    chk({nm, "_an"},  an,  8'hFF);
    chk({nm, "_seg"}, seg, 7'h7F);
    chk({nm, "_dp"},  dp,  1'b1);
  endtask

  initial begin
    logic [31:0] cur_d;
    logic [7:0]  cur_p;
    int          c1, c2, n;

    tv[0]  = '{32'h12345678, 8'h01, 0, 8'hFE, 7'b0000000, 1'b0, 7'b0000000};
    tv[1]  = '{32'h12345678, 8'h01, 7, 8'h7F, 7'b1111001, 1'b1, 7'b1111001};
    tv[2]  = '{32'h00000A05, 8'h00, 0, 8'hFE, 7'b0010010, 1'b1, 7'b0010010};
    tv[3]  = '{32'h00000A05, 8'h00, 1, 8'hFD, 7'b1000000, 1'b1, 7'b1000000};
    tv[4]  = '{32'h00000A05, 8'h00, 2, 8'hFB, 7'b0001000, 1'b1, 7'b0001000};
    tv[5]  = '{32'h00000A05, 8'h00, 3, 8'hF7, 7'b1111111, 1'b1, 7'b1000000};
    tv[6]  = '{32'h00000A05, 8'h00, 7, 8'h7F, 7'b1111111, 1'b1, 7'b1000000};
    tv[7]  = '{32'h00000000, 8'h80, 0, 8'hFE, 7'b1000000, 1'b1, 7'b1000000};
    tv[8]  = '{32'h00000000, 8'h80, 7, 8'h7F, 7'b1111111, 1'b0, 7'b1000000};
    tv[9]  = '{32'h89ABCDEF, 8'hAA, 3, 8'hF7, 7'b1000110, 1'b0, 7'b1000110};
    tv[10] = '{32'h89ABCDEF, 8'hAA, 6, 8'hBF, 7'b0010000, 1'b1, 7'b0010000};
    tv[11] = '{32'h0F000000, 8'h00, 7, 8'h7F, 7'b1111111, 1'b1, 7'b1000000};
    tv[12] = '{32'h0F000000, 8'h00, 4, 8'hEF, 7'b1000000, 1'b1, 7'b1000000};

    // Reset state
    #1 rst = 1'b1;
    tick(); tick();
    chk_blank("rst");
    chk("rst_ready", disp_ready, 1);
    chk("rst_fd", frame_done, 0);

    // Release: two blank slots then digit 0 (shadow 0) one cycle later
    rst = 1'b0;
    pos = 0;
    goto_pos(2);
    chk_blank("first_blank");
    goto_pos(3);
    chk("first_show_an", an, 8'hFE);
    chk("first_show_seg", seg, 7'b1000000);
    chk("first_show_dp", dp, 1'b1);

    // Table-driven display checks
    cur_d = '0;
    cur_p = '0;
    for (int i = 0; i < 13; i++) begin
      if (tv[i].data !== cur_d || tv[i].dpv !== cur_p) begin
        write(tv[i].data, tv[i].dpv);
        chk($sformatf("v%0d_ready_low", i), disp_ready, 0);
        cur_d = tv[i].data;
        cur_p = tv[i].dpv;
      end
      wait_fd();
      goto_pos(10 * tv[i].slot + 1);
      chk_blank($sformatf("v%0d_gap", i));
      goto_pos(10 * tv[i].slot + 3);
      chk($sformatf("v%0d_an", i),     an,     tv[i].an);
      chk($sformatf("v%0d_seg", i),    seg,    tv[i].seg);
      chk($sformatf("v%0d_dp", i),     dp,     tv[i].dpo);
      chk($sformatf("v%0d_an_nz", i),  an_nz,  tv[i].an);
      chk($sformatf("v%0d_seg_nz", i), seg_nz, tv[i].seg_nz);
    end

    // Back-to-back writes: second holds until the cycle after the boundary
    wait_fd();
    write(32'h00000011, 8'h00);
    disp_data  = 32'h00000022;
    disp_valid = 1'b1;
    n = 0;
    while (!disp_ready && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_ready", disp_ready, 1);
    chk("b2b_accept_after_boundary", frame_done, 1);
    c1 = cyc;
    pos = 0;
    tick();
    disp_valid = 1'b0;
    chk("b2b_fd_pulse_width", frame_done, 0);
    chk("b2b_ready_low", disp_ready, 0);
    goto_pos(3);
    chk("b2b_first_an", an, 8'hFE);
    chk("b2b_first_seg", seg, 7'b1111001);
    goto_pos(13);
    chk("b2b_first_d1", seg, 7'b1111001);
    wait_fd();
    c2 = cyc;
    chk("b2b_frame_period", c2 - c1, 80);
    goto_pos(3);
    chk("b2b_second_seg", seg, 7'b0100100);

    // Valid on the boundary cycle with pending empty
    goto_pos(79);
    chk("bnd_pre_ready", disp_ready, 1);
    disp_data  = 32'h00000033;
    disp_dp    = 8'h00;
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
    chk("bnd_fd", frame_done, 1);
    chk("bnd_captured", disp_ready, 0);
    pos = 0;
    goto_pos(3);
    chk("bnd_old_value", seg, 7'b0100100);
    wait_fd();
    goto_pos(3);
    chk("bnd_new_value", seg, 7'b0110000);

    // Asynchronous reset mid-SHOW at idx 5 with pending full
    write(32'h77777777, 8'hFF);
    chk("arst_pend_full", disp_ready, 0);
    goto_pos(55);
    chk("arst_pre_an", an, 8'hDF);
    #2 rst = 1'b1;
    #1;
    chk("arst_an_now", an, 8'hFF);
    chk("arst_seg_now", seg, 7'h7F);
    chk("arst_ready_now", disp_ready, 1);
    tick(); tick();
    rst = 1'b0;
    pos = 0;
    goto_pos(2);
    chk_blank("arst_restart_gap");
    goto_pos(3);
    chk("arst_restart_an", an, 8'hFE);
    chk("arst_restart_seg", seg, 7'b1000000);
    chk("arst_restart_dp", dp, 1'b1);
    chk("arst_restart_ready", disp_ready, 1);
    wait_fd();
    goto_pos(3);
    chk("arst_discard_seg", seg, 7'b1000000);
    goto_pos(13);
    chk("arst_discard_d1_an", an, 8'hFD);
    chk("arst_discard_d1_seg", seg, 7'h7F);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
